// File: rtl/clb_config_loader.sv
// -----------------------------------------------------------------------------
// clb_config_loader
//
// Serial configuration controller for an array of CLB logic pairs (4-input
// LUT + D-FF + FF/LUT output mux). A bitstream is accepted one bit per cycle.
// Bits are searched for an 8-bit sync header. After the header, one
// FF/LUT-select bit and one LUT truth table per pair are assembled into shadow
// registers. The shadow is copied to the live outputs in a single cycle, so
// the array never sees a partial configuration.
//
// Optional feature macro: CFG_PARITY_EN
//   defined   : a trailing even-parity bit follows the payload; a mismatch
//               moves to ERR and raises the sticky err_o flag.
//   undefined : no parity bit; the last payload bit goes straight to COMMIT
//               and err_o is tied low.
//
// Handshake: a bit is consumed on a rising edge where bit_valid_i and
// bit_ready_o are both high. bit_ready_o is a pure decode of the current
// state and never looks at bit_valid_i. The source may hold or drop
// bit_valid_i at will; dropping it stalls the loader with no timeout.
//
// Ports
//   clk_i         system clock, all state on the rising edge
//   reset_ni      asynchronous active-low reset
//   start_i       one-cycle request to begin a load (ignored while busy)
//   bit_in_i      serial configuration bit
//   bit_valid_i   bit_in_i is valid this cycle
//   bit_ready_o   loader accepts a bit this cycle (SYNC, LOAD, CHECK)
//   lut_cfg_o     live LUT tables, pair k at [k*LUT_W +: LUT_W]
//   switch_cfg_o  live FF/LUT select, bit k = pair k (1 = FF output)
//   prgm_b_o      active-low program mode to all LUTs
//   CLB_prgm_b_o  active-low one-cycle commit strobe to the CLB array
//   busy_o        load in progress
//   done_o        one-cycle pulse on a successful commit
//   err_o         sticky parity error flag
//   state_o       debug: current FSM state
//   bit_cnt_o     debug: payload bit counter
// -----------------------------------------------------------------------------
module clb_config_loader #(
    parameter int         NUM_PAIRS = 4,
    parameter int         LUT_W     = 16,
    parameter logic [7:0] SYNC_WORD = 8'hA5,
    localparam int        TOTAL     = NUM_PAIRS * (1 + LUT_W),
    localparam int        CNT_W     = $clog2(TOTAL)
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       start_i,
    input  logic                       bit_in_i,
    input  logic                       bit_valid_i,
    output logic                       bit_ready_o,
    output logic [NUM_PAIRS*LUT_W-1:0] lut_cfg_o,
    output logic [NUM_PAIRS-1:0]       switch_cfg_o,
    output logic                       prgm_b_o,
    output logic                       CLB_prgm_b_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [2:0]                 state_o,
    output logic [CNT_W-1:0]           bit_cnt_o
);

    localparam int PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int SLOT_W = $clog2(LUT_W + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_LOAD   = 3'd2,
        S_CHECK  = 3'd3,
        S_COMMIT = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t                            state_q, state_d;
    logic [7:0]                        sync_q, sync_d;
    logic [CNT_W-1:0]                  bit_cnt_q, bit_cnt_d;
    logic [PAIR_W-1:0]                 pair_q, pair_d;
    logic [SLOT_W-1:0]                 slot_q, slot_d;
    logic [NUM_PAIRS-1:0][LUT_W-1:0]   sh_lut_q, sh_lut_d;
    logic [NUM_PAIRS-1:0]              sh_sw_q, sh_sw_d;
    logic [NUM_PAIRS-1:0][LUT_W-1:0]   live_lut_q;
    logic [NUM_PAIRS-1:0]              live_sw_q;

    logic       accept;
    logic [7:0] sync_next;
    logic       sync_hit;

    // State-only decodes; none of these depend on bit_valid_i.
    assign bit_ready_o  = (state_q == S_SYNC) || (state_q == S_LOAD) || (state_q == S_CHECK);
    assign busy_o       = bit_ready_o || (state_q == S_COMMIT);
    assign prgm_b_o     = !busy_o;
    assign CLB_prgm_b_o = (state_q != S_COMMIT);
    assign done_o       = (state_q == S_DONE);
    assign state_o      = state_q;
    assign bit_cnt_o    = bit_cnt_q;
    assign lut_cfg_o    = live_lut_q;
    assign switch_cfg_o = live_sw_q;

    assign accept    = bit_valid_i && bit_ready_o;
    // Shifter is LSB-in, so the header compare includes the bit arriving now.
    assign sync_next = {sync_q[6:0], bit_in_i};
    assign sync_hit  = (state_q == S_SYNC) && accept && (sync_next == SYNC_WORD);

`ifdef CFG_PARITY_EN
    logic par_q, par_d;
    logic err_q, err_d;
    logic par_fail;

    // Even parity: running XOR of the payload XOR the parity bit must be 0.
    assign par_fail = par_q ^ bit_in_i;
    assign err_o    = err_q;

    always_comb begin
        par_d = par_q;
        err_d = err_q;
        if (((state_q == S_IDLE) || (state_q == S_ERR)) && start_i) begin
            err_d = 1'b0;
        end
        if (sync_hit) begin
            par_d = 1'b0;
        end
        if ((state_q == S_LOAD) && accept) begin
            par_d = par_q ^ bit_in_i;
        end
        if ((state_q == S_CHECK) && accept && par_fail) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            par_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            par_q <= par_d;
            err_q <= err_d;
        end
    end
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sync_d    = sync_q;
        bit_cnt_d = bit_cnt_q;
        pair_d    = pair_q;
        slot_d    = slot_q;
        sh_lut_d  = sh_lut_q;
        sh_sw_d   = sh_sw_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start_i) begin
                    state_d = S_SYNC;
                    sync_d  = 8'h00;
                end
            end
            S_SYNC: begin
                if (accept) begin
                    sync_d = sync_next;
                    if (sync_hit) begin
                        state_d   = S_LOAD;
                        bit_cnt_d = '0;
                        pair_d    = '0;
                        slot_d    = '0;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    // Slot 0 is the select bit; slots 1..LUT_W shift the LUT
                    // in MSB first, so the first LUT bit lands in the MSB.
                    if (slot_q == '0) begin
                        sh_sw_d[pair_q] = bit_in_i;
                    end else begin
                        sh_lut_d[pair_q] = {sh_lut_q[pair_q][LUT_W-2:0], bit_in_i};
                    end
                    if (slot_q == SLOT_W'(LUT_W)) begin
                        slot_d = '0;
                        pair_d = pair_q + PAIR_W'(1);
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                    if (bit_cnt_q == CNT_W'(TOTAL - 1)) begin
`ifdef CFG_PARITY_EN
                        state_d = S_CHECK;
`else
                        state_d = S_COMMIT;
`endif
                    end
                end
            end
            S_CHECK: begin
`ifdef CFG_PARITY_EN
                if (accept) begin
                    state_d = par_fail ? S_ERR : S_COMMIT;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_COMMIT: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            sync_q     <= 8'h00;
            bit_cnt_q  <= '0;
            pair_q     <= '0;
            slot_q     <= '0;
            sh_lut_q   <= '0;
            sh_sw_q    <= '0;
            live_lut_q <= '0;
            live_sw_q  <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            bit_cnt_q <= bit_cnt_d;
            pair_q    <= pair_d;
            slot_q    <= slot_d;
            sh_lut_q  <= sh_lut_d;
            sh_sw_q   <= sh_sw_d;
            // The only place the live configuration is ever written.
            if (state_q == S_COMMIT) begin
                live_lut_q <= sh_lut_q;
                live_sw_q  <= sh_sw_q;
            end
        end
    end

endmodule

// File: tb/tb_clb_config_loader.sv
module tb_clb_config_loader;

  localparam int NP    = 2;
  localparam int LW    = 16;
  localparam int CFG_W = NP * (1 + LW);
  localparam int CNT_W = $clog2(CFG_W);
`ifdef CFG_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic             clk;
  logic             reset_ni;
  logic             start_i;
  logic             bit_in_i;
  logic             bit_valid_i;
  logic             bit_ready_o;
  logic [NP*LW-1:0] lut_cfg_o;
  logic [NP-1:0]    switch_cfg_o;
  logic             prgm_b_o;
  logic             CLB_prgm_b_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] bit_cnt_o;

  clb_config_loader #(.NUM_PAIRS(NP), .LUT_W(LW), .SYNC_WORD(8'hA5)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .start_i      (start_i),
    .bit_in_i     (bit_in_i),
    .bit_valid_i  (bit_valid_i),
    .bit_ready_o  (bit_ready_o),
    .lut_cfg_o    (lut_cfg_o),
    .switch_cfg_o (switch_cfg_o),
    .prgm_b_o     (prgm_b_o),
    .CLB_prgm_b_o (CLB_prgm_b_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .state_o      (state_o),
    .bit_cnt_o    (bit_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters and scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [CFG_W-1:0] exp_q[$];
  logic [CFG_W-1:0] model_cfg = '0;  // last committed {switch, lut}

  int done_cnt = 0;
  int clb_cnt  = 0;
  int prgm_cnt = 0;
  int done_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: strobe counting and commit scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_ni) begin
      if (!CLB_prgm_b_o) clb_cnt++;
      if (!prgm_b_o) prgm_cnt++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          check("commit_cfg", {switch_cfg_o, lut_cfg_o}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input bit gaps);
    int n = 0;
    if (gaps) begin
      bit_valid_i = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    bit_in_i    = b;
    bit_valid_i = 1'b1;
    while (bit_ready_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    bit_valid_i = 1'b0;
  endtask

  task automatic send_byte_msb(input logic [7:0] v, input bit gaps);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
  endtask

  task automatic pulse_start(output int st_cyc);
    start_i = 1'b1;
    st_cyc  = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // One frame: optional hunt prefix, header, payload, parity.
  // stall_at / abort_at count payload bits already sent (0 = off).
  task automatic run_load(input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                          input logic s0, input logic s1,
                          input logic [15:0] pre, input int pre_n,
                          input bit bad_par, input int stall_at,
                          input bit gaps, input int abort_at);
    logic pay[$];
    logic par;
    logic [CFG_W-1:0] exp_cfg;
    int st_cyc, d0, c0, p0, n;
    logic [LW-1:0] luts[NP];
    logic          sws[NP];
    luts[0] = l0; luts[1] = l1;
    sws[0]  = s0; sws[1]  = s1;
    // Payload order: per pair, select bit then LUT bits MSB first.
    for (int k = 0; k < NP; k++) begin
      pay.push_back(sws[k]);
      for (int j = LW - 1; j >= 0; j--) pay.push_back(luts[k][j]);
    end
    par = 1'b0;
    foreach (pay[i]) par = par ^ pay[i];
    if (bad_par) par = ~par;
    exp_cfg = '0;
    for (int k = 0; k < NP; k++) begin
      exp_cfg[k*LW +: LW] = luts[k];
      exp_cfg[NP*LW + k]  = sws[k];
    end

    d0 = done_cnt; c0 = clb_cnt; p0 = prgm_cnt;
    pulse_start(st_cyc);
    check("err_clear_on_start", err_o, 0);
    check("busy_after_start", busy_o, 1);
    for (int i = pre_n - 1; i >= 0; i--) send_bit(pre[i], gaps);
    send_byte_msb(8'hA5, gaps);

    for (int i = 0; i < pay.size(); i++) begin
      send_bit(pay[i], gaps);
      if (i + 1 == abort_at) begin
        reset_ni = 1'b0;
        #1;
        check("rst_lut", lut_cfg_o, 0);
        check("rst_sw", switch_cfg_o, 0);
        check("rst_prgm_b", prgm_b_o, 1);
        check("rst_clb_prgm_b", CLB_prgm_b_o, 1);
        check("rst_ready", bit_ready_o, 0);
        check("rst_busy", busy_o, 0);
        @(posedge clk); #1;
        reset_ni  = 1'b1;
        model_cfg = '0;
        return;
      end
      if (i + 1 == stall_at) begin
        check("cnt_before_stall", bit_cnt_o, stall_at);
        for (int j = 0; j < 5; j++) begin
          if (j == 2) start_i = 1'b1;
          @(posedge clk); #1;
          start_i = 1'b0;
        end
        check("cnt_held_in_stall", bit_cnt_o, stall_at);
        check("busy_in_stall", busy_o, 1);
      end
    end

    if (!bad_par) exp_q.push_back(exp_cfg);
`ifdef CFG_PARITY_EN
    send_bit(par, gaps);
`endif

    if (bad_par) begin
      check("err_set", err_o, 1);
      check("err_busy", busy_o, 0);
      check("err_prgm_b", prgm_b_o, 1);
      check("err_ready", bit_ready_o, 0);
      repeat (4) @(posedge clk);
      #1;
      check("err_sticky", err_o, 1);
      check("err_cfg_kept", {switch_cfg_o, lut_cfg_o}, model_cfg);
      check("err_no_done", done_cnt - d0, 0);
      check("err_no_commit", clb_cnt - c0, 0);
    end else begin
      n = 0;
      while (done_cnt == d0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("done_seen", done_cnt - d0, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("done_single", done_cnt - d0, 1);
      check("clb_strobe_one_cycle", clb_cnt - c0, 1);
      check("prgm_low_window", prgm_cnt - p0, done_cyc - st_cyc - 1);
      check("idle_after_done", busy_o, 0);
      if (!gaps && stall_at == 0 && pre_n == 0)
        check("latency", done_cyc - st_cyc + 1, 1 + 8 + CFG_W + PAR_BITS + 2);
      model_cfg = exp_cfg;
      check("live_cfg", {switch_cfg_o, lut_cfg_o}, model_cfg);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_ni    = 1'b0;
    start_i     = 1'b0;
    bit_in_i    = 1'b0;
    bit_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_lut", lut_cfg_o, 0);
    check("reset_sw", switch_cfg_o, 0);
    check("reset_prgm_b", prgm_b_o, 1);
    check("reset_clb_prgm_b", CLB_prgm_b_o, 1);
    check("reset_ready", bit_ready_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_err", err_o, 0);
    reset_ni = 1'b1;
    @(posedge clk); #1;

    // Bits offered while idle are not consumed.
    bit_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bit_valid_i = 1'b0;
    check("idle_ignores_bits", busy_o, 0);

    // Basic load.
    run_load(16'h8000, 16'hFFFE, 1'b1, 1'b0, 16'h0, 0, 1'b0, 0, 1'b0, 0);
    check("basic_lut", lut_cfg_o, 32'hFFFE_8000);
    check("basic_sw", switch_cfg_o, 2'b01);

    // Sync hunt: 0x3C, 0x5A precede the header.
    run_load(16'h1234, 16'h0F0F, 1'b0, 1'b1, 16'h3C5A, 16, 1'b0, 0, 1'b0, 0);
    check("hunt_pair0_lut", lut_cfg_o[15:0], 16'h1234);

`ifdef CFG_PARITY_EN
    // Parity error keeps the previous configuration; next start clears err.
    run_load(16'h8000, 16'hFFFE, 1'b1, 1'b0, 16'h0, 0, 1'b1, 0, 1'b0, 0);
`endif

    // Stall after the 10th payload bit with a start poke during LOAD.
    run_load(16'h8000, 16'hFFFE, 1'b1, 1'b0, 16'h0, 0, 1'b0, 10, 1'b0, 0);
    check("stall_cfg_same", {switch_cfg_o, lut_cfg_o}, {2'b01, 32'hFFFE_8000});

    // Reset after 20 payload bits, then a clean load.
    run_load(16'hDEAD, 16'hBEEF, 1'b1, 1'b1, 16'h0, 0, 1'b0, 0, 1'b0, 20);
    run_load(16'h00F0, 16'hA001, 1'b0, 1'b1, 16'h0, 0, 1'b0, 0, 1'b0, 0);

    // Randomized frames with random valid gaps.
    for (int t = 0; t < 6; t++) begin
      run_load(LW'($urandom), LW'($urandom), 1'($urandom), 1'($urandom),
               16'($urandom), $urandom_range(0, 1) * 8, 1'b0,
               (t % 2 == 0) ? int'($urandom_range(1, CFG_W - 1)) : 0, 1'b1, 0);
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
